// File: rtl/fetch_unit_pq_pkg.sv
// Shared definitions for the prefetching instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pq_if.sv
// Instruction-memory read port: request handshake plus single-pulse response.
interface fetch_unit_pq_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/fetch_unit_pq_queue.sv
// Prefetch queue: synchronous FIFO with flush; flush overrides push and pop.
module fetch_queue #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             empty
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Upstream credit must never let a push land on a full queue.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full));
  end

endmodule

// File: rtl/fetch_unit_pq.sv
// Sequential instruction fetcher: one outstanding memory read, credit-limited
// prefetch into a queue, and a redirect path that flushes and re-targets.
module fetch_unit_pq
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_unit_pq_if.master       mem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                  busy
);

  localparam int unsigned     LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(FIFO_DEPTH);

  fetch_state_t                     state;
  logic [ADDR_WIDTH-1:0]            fetch_pc;
  logic [ADDR_WIDTH-1:0]            tag_pc;
  logic                             drop;
  logic                             hs;
  logic                             rsp;
  logic                             push;
  logic                             pop;
  logic                             can_issue;
  logic                             can_issue_post;
  logic                             q_empty;
  logic [LW-1:0]                    q_level;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

  assign hs   = mem.mem_req_valid & mem.mem_req_ready;
  assign rsp  = (state == WAIT) & mem.mem_rsp_valid;
  assign push = rsp & ~drop & ~redirect_valid;
  assign pop  = out_valid & out_ready;

  // An outstanding response always owns a reserved queue slot.
  assign can_issue      = enable & ((q_level + LW'(state == WAIT)) < DEPTH_L);
  assign can_issue_post = enable & ((q_level + LW'(push)) < DEPTH_L);

  assign out_valid = ~q_empty;
  assign out_pc    = head[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
  assign out_instr = head[DATA_WIDTH-1:0];
  assign level     = q_level;
  assign busy      = (state != IDLE);

  // Fetch FSM with registered request outputs; redirect outranks all events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      fetch_pc          <= RESET_PC;
      tag_pc            <= '0;
      drop              <= 1'b0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end else if (can_issue) begin
            state             <= REQ;
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_addr  <= fetch_pc;
          end
        end
        REQ: begin
          if (hs) begin
            state             <= WAIT;
            mem.mem_req_valid <= 1'b0;
            tag_pc            <= fetch_pc;
            fetch_pc          <= redirect_valid ? redirect_pc : fetch_pc + 1'b1;
            drop              <= redirect_valid;
          end else if (redirect_valid) begin
            state             <= IDLE;
            mem.mem_req_valid <= 1'b0;
            fetch_pc          <= redirect_pc;
          end
        end
        WAIT: begin
          if (redirect_valid) fetch_pc <= redirect_pc;
          if (rsp) begin
            drop <= 1'b0;
            // fetch_pc was already advanced at the handshake
            if (!redirect_valid && can_issue_post) begin
              state             <= REQ;
              mem.mem_req_valid <= 1'b1;
              mem.mem_req_addr  <= fetch_pc;
            end else begin
              state <= IDLE;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state             <= IDLE;
          mem.mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({tag_pc, mem.mem_rsp_data}),
    .head      (head),
    .level     (q_level),
    .empty     (q_empty)
  );

endmodule
